// File: rtl/norm_unit.sv
// -----------------------------------------------------------------------------
// norm_unit
//
// Multi-cycle normalizer for the execute stage; the inverse of the barrel
// shifter. Given an operand it returns the left-shift amount that normalizes
// it, together with the normalized value. It serves count-leading-zeros
// (unsigned mode) and count-redundant-sign-bits (signed mode).
//
// The search is binary, with one step per clock for k = 4,3,2,1,0 and
// w = 2^k. Each step shifts X left by w, and adds w to the count, when the
// tested top bits of X are redundant.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   request; accepted only in IDLE or DONE
//   signed_mode  in   1   0 = leading zeros, 1 = redundant sign bits
//   A            in  32   operand, captured at accept
//   busy         out  1   search running
//   done         out  1   one-cycle pulse; results valid from this cycle on
//   shamt        out  6   normalize amount, 0..32
//   out          out 32   A << shamt
//   zero         out  1   operand all-zero (unsigned), or all-zero/all-one
//                         (signed)
//
// Build option
//   NORM_EARLY_EXIT_EN : zero-class operands skip the search. For these
//                        operands busy is high for one cycle and done
//                        follows on the next edge. The results are the same
//                        as with the full search.
// -----------------------------------------------------------------------------
module norm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_mode,
  input  logic [31:0] A,
  output logic        busy,
  output logic        done,
  output logic [5:0]  shamt,
  output logic [31:0] out,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;          // working value being normalized
  logic [5:0]  cnt_q, cnt_d;      // accumulated shift
  logic [2:0]  k_q, k_d;          // current step, w = 2^k
  logic        sgn_q, sgn_d;      // captured signed_mode
  logic        a_zero_q, a_zero_d; // captured A == 0
  logic        a_ones_q, a_ones_d; // captured A == all ones
`ifdef NORM_EARLY_EXIT_EN
  logic        early_q, early_d;  // zero-class operand, skip the search
`endif

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  shamt_q, shamt_d;
  logic [31:0] out_q, out_d;
  logic        zero_q, zero_d;

  logic        accept;
  logic [5:0]  w;
  logic [31:0] test_v;
  logic        step_ok;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    sgn_d    = sgn_q;
    a_zero_d = a_zero_q;
    a_ones_d = a_ones_q;
`ifdef NORM_EARLY_EXIT_EN
    early_d  = early_q;
`endif
    shamt_d  = shamt_q;
    out_d    = out_q;
    zero_d   = zero_q;

    accept = start && ((state_q == IDLE) || (state_q == DONE));
    w      = 6'd1 << k_q;

    // Signed test: the top w+1 bits are all equal exactly when the top w
    // bits of X ^ (X << 1) are zero. Both modes therefore reduce to the
    // same "top w bits are zero" check.
    test_v  = sgn_q ? (x_q ^ (x_q << 1)) : x_q;
    step_ok = ((test_v >> (6'd32 - w)) == 32'd0);

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = STEP;
          x_d      = A;
          cnt_d    = 6'd0;
          k_d      = 3'd4;
          sgn_d    = signed_mode;
          a_zero_d = (A == 32'd0);
          a_ones_d = (A == 32'hFFFF_FFFF);
`ifdef NORM_EARLY_EXIT_EN
          early_d  = (A == 32'd0) || (signed_mode && (A == 32'hFFFF_FFFF));
`endif
        end else begin
          state_d = IDLE;
        end
      end

      STEP: begin
`ifdef NORM_EARLY_EXIT_EN
        if (early_q) begin
          // The fixup values the full search would have produced.
          state_d = DONE;
          shamt_d = sgn_q ? 6'd31 : 6'd32;
          out_d   = (sgn_q && a_ones_q) ? 32'h8000_0000 : 32'd0;
          zero_d  = 1'b1;
        end else
`endif
        begin
          if (step_ok) begin
            x_d   = x_q << w;
            cnt_d = cnt_q + w;
          end
          if (k_q == 3'd0) begin
            state_d = DONE;
            // An unsigned zero operand stops at 31 in the search. Its
            // architectural answer is a full-width shift of 32.
            if (!sgn_q && a_zero_q) begin
              shamt_d = 6'd32;
              out_d   = 32'd0;
              zero_d  = 1'b1;
            end else begin
              shamt_d = cnt_d;
              out_d   = x_d;
              zero_d  = a_zero_q || (sgn_q && a_ones_q);
            end
          end else begin
            k_d = k_q - 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == STEP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= 32'd0;
      cnt_q    <= 6'd0;
      k_q      <= 3'd0;
      sgn_q    <= 1'b0;
      a_zero_q <= 1'b0;
      a_ones_q <= 1'b0;
`ifdef NORM_EARLY_EXIT_EN
      early_q  <= 1'b0;
`endif
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shamt_q  <= 6'd0;
      out_q    <= 32'd0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      sgn_q    <= sgn_d;
      a_zero_q <= a_zero_d;
      a_ones_q <= a_ones_d;
`ifdef NORM_EARLY_EXIT_EN
      early_q  <= early_d;
`endif
      busy_q   <= busy_d;
      done_q   <= done_d;
      shamt_q  <= shamt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign shamt = shamt_q;
  assign out   = out_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_norm_unit.sv
// -----------------------------------------------------------------------------
// tb_norm_unit
//
// Directed bench for norm_unit. Every expected value is hand-derived from
// the operand.
//
// Timing convention: "edge 0" is the edge after which start is driven. The
// start is sampled at edge 1. Samples are taken 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_norm_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] A;
  logic        busy;
  logic        done;
  logic [5:0]  shamt;
  logic [31:0] out;
  logic        zero;

  int total;
  int bad;

  norm_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .busy        (busy),
    .done        (done),
    .shamt       (shamt),
    .out         (out),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NORM_EARLY_EXIT_EN
  localparam int ZERO_LAT  = 2;
  localparam int ZERO_BUSY = 1;
`else
  localparam int ZERO_LAT  = 6;
  localparam int ZERO_BUSY = 5;
`endif

  // Issue a one-cycle start and observe the next 10 edges. The outputs are:
  // lat   = first edge after which done was seen (0 if it never was),
  // bcnt  = busy cycles, and dcnt = done pulses.
  // The results are captured in the done cycle. When poke_n > 0, a second
  // start with A = 1 is driven after edge poke_n, for one cycle.
  task automatic issue(input logic [31:0] a, input logic sm, input int poke_n,
                       output int lat, output int bcnt, output int dcnt,
                       output logic [5:0] r_sh, output logic [31:0] r_out,
                       output logic r_z);
    lat = 0; bcnt = 0; dcnt = 0; r_sh = '0; r_out = '0; r_z = 1'b0;
    @(posedge clk); #1;
    A = a; signed_mode = sm; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (poke_n > 0 && n == poke_n) begin
        start = 1'b1; A = 32'd1; signed_mode = 1'b0;
      end
      if (poke_n > 0 && n == poke_n + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = n; r_sh = shamt; r_out = out; r_z = zero;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, shamt, out, zero} !== 41'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b shamt=%0d out=%h zero=%b want all 0",
               busy, done, shamt, out, zero);
    end
    #2 rst = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic sm,
                          input logic [5:0] e_sh, input logic [31:0] e_out,
                          input logic e_z, input int e_lat, input int e_busy);
    int lat, bcnt, dcnt;
    logic [5:0] r_sh; logic [31:0] r_out; logic r_z;
    issue(a, sm, 0, lat, bcnt, dcnt, r_sh, r_out, r_z);
    total++;
    if (r_sh !== e_sh || r_out !== e_out || r_z !== e_z) begin
      bad++;
      $display("FAIL %s result got shamt=%0d out=%h zero=%b want shamt=%0d out=%h zero=%b",
               name, r_sh, r_out, r_z, e_sh, e_out, e_z);
    end
    total++;
    if (lat !== e_lat || dcnt !== 1) begin
      bad++;
      $display("FAIL %s latency got lat=%0d dones=%0d want lat=%0d dones=1",
               name, lat, dcnt, e_lat);
    end
    total++;
    if (bcnt !== e_busy) begin
      bad++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, bcnt, e_busy);
    end
    // The results must still be held after the operation returns to idle.
    total++;
    if (shamt !== e_sh || out !== e_out || zero !== e_z) begin
      bad++;
      $display("FAIL %s held got shamt=%0d out=%h want shamt=%0d out=%h",
               name, shamt, out, e_sh, e_out);
    end
  endtask

  task automatic test_unsigned;
    check_op("u_00010000", 32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0, 6, 5);
    check_op("u_zero",     32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1, ZERO_LAT, ZERO_BUSY);
    check_op("u_ffffffff", 32'hFFFF_FFFF, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b0, 6, 5);
  endtask

  task automatic test_signed;
    check_op("s_ffff8000", 32'hFFFF_8000, 1'b1, 6'd16, 32'h8000_0000, 1'b0, 6, 5);
    check_op("s_00000001", 32'h0000_0001, 1'b1, 6'd30, 32'h4000_0000, 1'b0, 6, 5);
    check_op("s_ffffffff", 32'hFFFF_FFFF, 1'b1, 6'd31, 32'h8000_0000, 1'b1, ZERO_LAT, ZERO_BUSY);
    check_op("s_zero",     32'h0000_0000, 1'b1, 6'd31, 32'h0000_0000, 1'b1, ZERO_LAT, ZERO_BUSY);
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, dcnt;
    logic [5:0] r_sh; logic [31:0] r_out; logic r_z;
    issue(32'h8000_0000, 1'b0, 2, lat, bcnt, dcnt, r_sh, r_out, r_z);
    total++;
    if (r_sh !== 6'd0 || r_out !== 32'h8000_0000 || r_z !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start result got shamt=%0d out=%h want shamt=0 out=80000000",
               r_sh, r_out);
    end
    total++;
    if (dcnt !== 1 || lat !== 6) begin
      bad++;
      $display("FAIL ignore_start dones got %0d at %0d want 1 at 6", dcnt, lat);
    end
  endtask

  task automatic test_reset_mid;
    int dcnt;
    int lat, bcnt, dc2;
    logic [5:0] r_sh; logic [31:0] r_out; logic r_z;
    // Load a nonzero result first, so that the clearing by reset is visible.
    check_op("pre_reset", 32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0, 6, 5);
    @(posedge clk); #1;
    A = 32'h0000_0100; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, shamt, out, zero} !== 41'd0) begin
      bad++;
      $display("FAIL reset_mid_async got busy=%b done=%b shamt=%0d out=%h zero=%b want all 0",
               busy, done, shamt, out, zero);
    end
    #1 rst = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    total++;
    if (dcnt !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got %0d active cycles want 0", dcnt);
    end
    issue(32'h0000_FFFF, 1'b0, 0, lat, bcnt, dc2, r_sh, r_out, r_z);
    total++;
    if (r_sh !== 6'd16 || r_out !== 32'hFFFF_0000 || lat !== 6) begin
      bad++;
      $display("FAIL post_reset got shamt=%0d out=%h lat=%0d want shamt=16 out=ffff0000 lat=6",
               r_sh, r_out, lat);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    logic [5:0] s1, s2; logic [31:0] o1, o2;
    d1 = 0; d2 = 0; s1 = '0; s2 = '0; o1 = '0; o2 = '0;
    @(posedge clk); #1;
    A = 32'h0001_0000; signed_mode = 1'b0; start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 1) A = 32'h0000_FFFF;  // captured only when DONE re-accepts
      if (n == 7) begin
        start = 1'b0;
        total++;
        if (shamt !== 6'd15 || out !== 32'h8000_0000) begin
          bad++;
          $display("FAIL b2b_hold_at_accept got shamt=%0d out=%h want 15 80000000", shamt, out);
        end
      end
      if (done) begin
        if (d1 == 0) begin d1 = n; s1 = shamt; o1 = out; end
        else if (d2 == 0) begin d2 = n; s2 = shamt; o2 = out; end
      end
    end
    total++;
    if (d1 !== 6 || d2 !== 12) begin
      bad++;
      $display("FAIL b2b_timing got dones at %0d,%0d want 6,12", d1, d2);
    end
    total++;
    if (s1 !== 6'd15 || o1 !== 32'h8000_0000 || s2 !== 6'd16 || o2 !== 32'hFFFF_0000) begin
      bad++;
      $display("FAIL b2b_results got %0d/%h %0d/%h want 15/80000000 16/ffff0000",
               s1, o1, s2, o2);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // A global bound, so that the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
